// File: rtl/rs_syndrome_engine_if.sv
// rs_syndrome_engine_if: symbol-in / syndrome-out bundle for rs_syndrome_engine.
//   Parameter NSYN sets the o_syn width (8*NSYN).
//   master modport: symbol producer and result consumer
//     (drives i_frame_sync, i_data, i_data_sync, i_erasure, i_ready).
//   slave modport: the syndrome engine
//     (drives o_syn, o_zero, o_erasures, o_valid, o_short, o_overrun).
interface rs_syndrome_engine_if #(
  parameter int NSYN = 4
);
  logic                i_frame_sync;
  logic [7:0]          i_data;
  logic                i_data_sync;
  logic                i_erasure;
  logic [8*NSYN-1:0]   o_syn;
  logic                o_zero;
  logic [7:0]          o_erasures;
  logic                o_valid;
  logic                i_ready;
  logic                o_short;
  logic                o_overrun;

  modport master (
    output i_frame_sync, i_data, i_data_sync, i_erasure, i_ready,
    input  o_syn, o_zero, o_erasures, o_valid, o_short, o_overrun
  );

  modport slave (
    input  i_frame_sync, i_data, i_data_sync, i_erasure, i_ready,
    output o_syn, o_zero, o_erasures, o_valid, o_short, o_overrun
  );
endinterface

// File: rtl/rs_syndrome_engine.sv
// rs_syndrome_engine: Reed-Solomon syndrome engine over GF(2^8), polynomial
// 0x11D, alpha = 0x02, roots alpha^0 .. alpha^(NSYN-1).
//   i_clk, i_res : clock and synchronous active-high reset
//   bus (slave)  : byte symbol stream in (i_data/i_data_sync/i_frame_sync/
//                  i_erasure), held syndrome result out with ready/valid
//                  (o_syn/o_zero/o_erasures/o_valid/i_ready), one-cycle
//                  status pulses o_short and o_overrun.
// Parameters: NSYN syndromes (2..8), N symbols per codeword (2..255).
// Optional feature macro: ERASURE_CNT_EN enables the per-codeword erasure
// counter; without it o_erasures is constant 0 and i_erasure is ignored.
module rs_syndrome_engine #(
  parameter int NSYN = 4,
  parameter int N    = 32
) (
  input  logic               i_clk,
  input  logic               i_res,
  rs_syndrome_engine_if.slave bus
);

  localparam int DATA_W = 8;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        cnt;
  logic [8*NSYN-1:0]        acc;
  logic [8*NSYN-1:0]        acc_next;
  logic                     start;
  logic                     step;
  logic                     last;
  logic                     xfer;

  // Multiply by alpha in GF(2^8) with reduction polynomial 0x11D.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  // Constant multiply by alpha^j; j is elaboration-constant per syndrome,
  // so this unrolls into a small XOR network.
  function automatic logic [7:0] mul_alpha_pow(input logic [7:0] x, input int j);
    logic [7:0] r;
    r = x;
    for (int k = 0; k < 8; k++)
      if (k < j) r = xtime(r);
    return r;
  endfunction

  // A frame_sync symbol always (re)starts a codeword, even mid-frame.
  assign start = bus.i_data_sync && bus.i_frame_sync;
  assign step  = bus.i_data_sync && !bus.i_frame_sync && (state == ACCUM);
  assign last  = step && (cnt == DATA_W'(N - 1));
  assign xfer  = bus.o_valid && bus.i_ready;

  always_comb begin
    acc_next = '0;
    for (int j = 0; j < NSYN; j++)
      acc_next[8*j +: 8] = start ? bus.i_data
                                 : (mul_alpha_pow(acc[8*j +: 8], j) ^ bus.i_data);
  end

  // Accumulate stage -> held result register
  always_ff @(posedge i_clk) begin
    if (i_res) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      bus.o_syn     <= '0;
      bus.o_zero    <= 1'b0;
      bus.o_valid   <= 1'b0;
      bus.o_short   <= 1'b0;
      bus.o_overrun <= 1'b0;
    end else begin
      bus.o_short   <= start && (state == ACCUM);
      bus.o_overrun <= last && bus.o_valid && !bus.i_ready;

      if (start || step)
        acc <= acc_next;

      if (start) begin
        cnt   <= 8'd1;
        state <= ACCUM;
      end else if (last) begin
        cnt   <= '0;
        state <= IDLE;
      end else if (step) begin
        cnt   <= cnt + 8'd1;
      end

      // A load wins over a transfer on the same edge, so valid stays high.
      if (last) begin
        bus.o_syn   <= acc_next;
        bus.o_zero  <= (acc_next == '0);
        bus.o_valid <= 1'b1;
      end else if (xfer) begin
        bus.o_valid <= 1'b0;
      end
    end
  end

`ifdef ERASURE_CNT_EN
  logic [7:0] ers;
  logic [7:0] ers_next;

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic e);
    return (e && (c != 8'hFF)) ? c + 8'd1 : c;
  endfunction

  assign ers_next = start ? {7'd0, bus.i_erasure} : sat_inc(ers, bus.i_erasure);

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      ers            <= '0;
      bus.o_erasures <= '0;
    end else begin
      if (start || step)
        ers <= ers_next;
      if (last)
        bus.o_erasures <= ers_next;
    end
  end
`else
  logic unused_erasure;
  assign unused_erasure = bus.i_erasure;
  assign bus.o_erasures = 8'd0;
`endif

endmodule

// File: tb/tb_rs_syndrome_engine.sv
module tb_rs_syndrome_engine;

  typedef struct packed {
    logic [31:0] syn;
    logic        zero;
    logic [7:0]  ers;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_syndrome_engine_if #(.NSYN(4)) bus ();
  rs_syndrome_engine_if #(.NSYN(4)) bus28 ();

  rs_syndrome_engine #(.NSYN(4), .N(32)) dut (
    .i_clk (clk),
    .i_res (rst),
    .bus   (bus)
  );

  rs_syndrome_engine #(.NSYN(4), .N(28)) dut28 (
    .i_clk (clk),
    .i_res (rst),
    .bus   (bus28)
  );

  int   checks = 0;
  int   errors = 0;
  int   short_cnt = 0;
  int   ovr_cnt = 0;
  int   xfer_cnt = 0;
  res_t sbq[$];
  res_t mon_exp;

  logic [7:0] cw   [0:254];
  logic       er_v [0:254];

  // ---------------- reference model (direct polynomial evaluation) -------------
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = xt(aa);
    end
    return r;
  endfunction

  function automatic logic [7:0] gpow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 0; k < (e % 255); k++) r = xt(r);
    return r;
  endfunction

  function automatic res_t model(input int n);
    res_t r;
    int   ec;
    r.syn = '0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < n; i++)
        r.syn[8*j +: 8] = r.syn[8*j +: 8] ^ gmul(cw[i], gpow(j * (n - 1 - i)));
    r.zero = (r.syn == 32'h0);
    ec = 0;
    for (int i = 0; i < n; i++)
      if (er_v[i] && ec < 255) ec++;
`ifdef ERASURE_CNT_EN
    r.ers = 8'(ec);
`else
    r.ers = 8'd0;
`endif
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_short)   short_cnt++;
      if (bus.o_overrun) ovr_cnt++;
      if (bus.o_valid && bus.i_ready) begin
        xfer_cnt++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got syn=%h with no result expected", bus.o_syn);
        end else begin
          mon_exp = sbq.pop_front();
          if (bus.o_syn !== mon_exp.syn) begin
            errors++;
            $display("FAIL syn: got %h expected %h", bus.o_syn, mon_exp.syn);
          end
          checks++;
          if (bus.o_zero !== mon_exp.zero) begin
            errors++;
            $display("FAIL zero: got %b expected %b", bus.o_zero, mon_exp.zero);
          end
          checks++;
          if (bus.o_erasures !== mon_exp.ers) begin
            errors++;
            $display("FAIL erasures: got %0d expected %0d", bus.o_erasures, mon_exp.ers);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_sym(input logic [7:0] d, input logic fs, input logic er);
    bus.i_data       = d;
    bus.i_frame_sync = fs;
    bus.i_erasure    = er;
    bus.i_data_sync  = 1'b1;
    @(posedge clk); #1;
    bus.i_data_sync  = 1'b0;
    bus.i_frame_sync = 1'b0;
    bus.i_erasure    = 1'b0;
  endtask

  task automatic send_cw(input int n, input bit push, input bit gaps);
    if (push) sbq.push_back(model(n));
    for (int i = 0; i < n; i++) begin
      send_sym(cw[i], (i == 0), er_v[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 255; i++) begin
      cw[i]   = 8'h00;
      er_v[i] = 1'b0;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 255; i++) begin
      cw[i]   = 8'($urandom_range(0, 255));
      er_v[i] = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 300 && sbq.size() != 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
    checks++;
    if (bus.o_syn !== 32'h0) begin errors++; $display("FAIL reset_syn: got %h expected 0", bus.o_syn); end
    checks++;
    if (bus.o_zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", bus.o_zero); end
    checks++;
    if (bus.o_erasures !== 8'd0) begin errors++; $display("FAIL reset_erasures: got %0d expected 0", bus.o_erasures); end
    checks++;
    if (bus.o_short !== 1'b0 || bus.o_overrun !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got short=%b overrun=%b expected 0 0", bus.o_short, bus.o_overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_zero();
    int x0, s0;
    x0 = xfer_cnt; s0 = short_cnt;
    fill_zero();
    send_cw(32, 1, 0);
    wait_drain();
    checks++;
    if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL zero_cw_count: got %0d results expected 1", xfer_cnt - x0); end
    checks++;
    if (short_cnt != s0) begin errors++; $display("FAIL zero_cw_short: got %0d pulses expected 0", short_cnt - s0); end
    checks++;
    if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL zero_cw_valid_fall: got %b expected 0", bus.o_valid); end
  endtask

  task automatic test_degree1();
    fill_zero();
    cw[30] = 8'h01;
    sbq.push_back('{syn: 32'h08040201, zero: 1'b0, ers: 8'd0});
    send_cw(32, 0, 0);
    wait_drain();
  endtask

  task automatic test_degree0();
    fill_zero();
    cw[31] = 8'h01;
    sbq.push_back('{syn: 32'h01010101, zero: 1'b0, ers: 8'd0});
    send_cw(32, 0, 0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int x0;
    x0 = xfer_cnt;
    for (int r = 0; r < 4; r++) begin
      fill_rand();
      send_cw(32, 1, (r >= 2));
    end
    wait_drain();
    checks++;
    if (xfer_cnt - x0 != 4) begin errors++; $display("FAIL b2b_count: got %0d results expected 4", xfer_cnt - x0); end
  endtask

  task automatic test_short();
    int x0, s0;
    x0 = xfer_cnt; s0 = short_cnt;
    fill_rand();
    send_cw(10, 0, 0);
    fill_rand();
    send_cw(32, 1, 0);
    wait_drain();
    checks++;
    if (short_cnt - s0 != 1) begin errors++; $display("FAIL short_pulses: got %0d expected 1", short_cnt - s0); end
    checks++;
    if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL short_results: got %0d expected 1", xfer_cnt - x0); end
  endtask

  task automatic test_overrun();
    int   o0, x0;
    res_t eb;
    o0 = ovr_cnt; x0 = xfer_cnt;
    bus.i_ready = 1'b0;
    fill_rand();
    send_cw(32, 0, 0);
    fill_rand();
    eb = model(32);
    send_cw(32, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt - o0); end
    checks++;
    if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", bus.o_valid); end
    checks++;
    if (bus.o_syn !== eb.syn) begin errors++; $display("FAIL overrun_syn: got %h expected %h", bus.o_syn, eb.syn); end
    // Release ready exactly on the edge that loads the next result.
    fill_rand();
    sbq.push_back(model(32));
    for (int i = 0; i < 31; i++) send_sym(cw[i], (i == 0), 1'b0);
    bus.i_ready = 1'b1;
    send_sym(cw[31], 1'b0, 1'b0);
    wait_drain();
    checks++;
    if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL load_xfer_overrun: got %0d pulses expected 1", ovr_cnt - o0); end
    checks++;
    if (xfer_cnt - x0 != 2) begin errors++; $display("FAIL load_xfer_count: got %0d expected 2", xfer_cnt - x0); end
  endtask

  task automatic test_erasure();
    fill_rand();
    er_v[3]  = 1'b1;
    er_v[17] = 1'b1;
    er_v[31] = 1'b1;
    send_cw(32, 1, 0);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    fill_rand();
    send_cw(15, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_syn !== 32'h0 || bus.o_valid !== 1'b0 || bus.o_zero !== 1'b0) begin
      errors++; $display("FAIL midreset_out: got syn=%h valid=%b zero=%b expected 0", bus.o_syn, bus.o_valid, bus.o_zero);
    end
    checks++;
    if (bus.o_erasures !== 8'd0 || bus.o_short !== 1'b0 || bus.o_overrun !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: got ers=%0d short=%b ovr=%b expected 0", bus.o_erasures, bus.o_short, bus.o_overrun);
    end
    rst = 1'b0;
    // Symbols without frame_sync after reset must be ignored.
    send_sym(8'h5A, 1'b0, 1'b0);
    send_sym(8'hA5, 1'b0, 1'b0);
    fill_rand();
    send_cw(32, 1, 0);
    wait_drain();
  endtask

  task automatic test_c2();
    int k;
    fill_zero();
    cw[27] = 8'h01;
    bus28.i_ready = 1'b0;
    for (int i = 0; i < 28; i++) begin
      bus28.i_data       = cw[i];
      bus28.i_frame_sync = (i == 0);
      bus28.i_data_sync  = 1'b1;
      @(posedge clk); #1;
    end
    bus28.i_data_sync  = 1'b0;
    bus28.i_frame_sync = 1'b0;
    k = 0;
    while (bus28.o_valid !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (bus28.o_valid !== 1'b1) begin errors++; $display("FAIL c2_valid: got %b expected 1", bus28.o_valid); end
    checks++;
    if (bus28.o_syn !== 32'h01010101) begin errors++; $display("FAIL c2_syn: got %h expected 01010101", bus28.o_syn); end
    checks++;
    if (bus28.o_zero !== 1'b0) begin errors++; $display("FAIL c2_zero: got %b expected 0", bus28.o_zero); end
    bus28.i_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus28.o_valid !== 1'b0) begin errors++; $display("FAIL c2_valid_fall: got %b expected 0", bus28.o_valid); end
  endtask

  initial begin
    bus.i_frame_sync   = 1'b0;
    bus.i_data         = 8'h00;
    bus.i_data_sync    = 1'b0;
    bus.i_erasure      = 1'b0;
    bus.i_ready        = 1'b1;
    bus28.i_frame_sync = 1'b0;
    bus28.i_data       = 8'h00;
    bus28.i_data_sync  = 1'b0;
    bus28.i_erasure    = 1'b0;
    bus28.i_ready      = 1'b1;
    test_reset();
    @(posedge clk); #1;
    test_all_zero();
    test_degree1();
    test_degree0();
    test_back_to_back();
    test_short();
    test_overrun();
    test_erasure();
    test_reset_mid();
    test_c2();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d pending expected 0", sbq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rs_syndrome_engine.md
# rs_syndrome_engine

Parametrised Reed-Solomon syndrome engine over GF(2^8) (primitive polynomial 0x11D, α = 0x02, first consecutive root α^0) for the CIRC C1/C2 decoding path. It accepts one byte-wide symbol stream, computes NSYN syndromes per N-symbol codeword with Horner accumulators, and presents them on a ready/valid output. It adds several features the first-generation syndrome calculator lacks:
- configurable codeword length and syndrome count;
- double buffering, so the next codeword accumulates while a result waits;
- an all-zero flag;
- short-frame and overrun detection;
- optional erasure counting.

## Interface
Parameters:
- NSYN, 4, number of syndromes S0..S(NSYN-1); legal 2..8
- N, 32, symbols per codeword (32 = C1, 28 = C2); legal 2..255

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_res  in  1  synchronous active-high reset
- i_frame_sync  in  1  marks the first symbol of a codeword; qualified by i_data_sync
- i_data  in  8  symbol byte; highest-degree coefficient first
- i_data_sync  in  1  symbol strobe; i_data valid this cycle
- i_erasure  in  1  erasure flag for the current symbol; qualified by i_data_sync
- o_syn  out  8*NSYN  syndromes; S_j in bits [8j+7:8j]
- o_zero  out  1  all syndromes of the held result are zero
- o_erasures  out  8  erased-symbol count of the held result
- o_valid  out  1  held result valid
- i_ready  in  1  consumer accepts the result when high together with o_valid
- o_short  out  1  one-cycle pulse: codeword aborted before N symbols
- o_overrun  out  1  one-cycle pulse: an unaccepted result was overwritten

## Operation
- Accumulator per syndrome: on each accepted symbol, S_j ← (S_j · α^j) XOR d.
  - S0 is a plain XOR.
  - Multiply by α^j is a constant GF multiplier, purely combinational.
- Symbol counter runs 0..N-1. States are IDLE and ACCUM.
- IDLE:
  - i_data_sync with i_frame_sync: S_j ← d, counter ← 1, erasure count ← i_erasure, go to ACCUM.
  - i_data_sync without i_frame_sync: ignored.
- ACCUM, i_data_sync without i_frame_sync: accumulate, counter increments, erasure count adds i_erasure.
- ACCUM, i_data_sync with i_frame_sync before N symbols:
  - o_short pulses and the partial result is discarded.
  - The symbol restarts a codeword exactly as in IDLE; state stays ACCUM.
- Nth symbol accepted:
  - The final accumulator values (including this symbol) load the output register.
  - o_zero ← (all S_j == 0) and o_erasures ← final count.
  - o_valid ← 1, state → IDLE.
- If N = 1-symbol-short codeword completion and a new frame_sync coincide, the frame_sync rule above applies.
- Output register holds its value until transfer (o_valid && i_ready); o_syn, o_zero and o_erasures stay stable while o_valid=1 and not transferred.
- Load when o_valid=1 and the current result is not transferring that cycle: overwrite the result, o_overrun pulses, o_valid stays 1.
- Load in the same cycle as a transfer: new result is loaded, o_valid stays 1, no overrun.
- Erasure count saturates at 255.
- Reset (any time, including mid-codeword):
  - state IDLE, counter 0, accumulators 0;
  - o_syn 0, o_zero 0, o_erasures 0;
  - o_valid 0, o_short 0, o_overrun 0.

## Timing
- Symbol throughput is one per clock; gaps (i_data_sync=0) are allowed anywhere.
- Latency: o_valid is high from the edge that samples the Nth symbol; results are visible in the following cycle.
- o_valid falls on the edge after transfer unless a load occurs on that same edge.
- o_short and o_overrun are registered and high for exactly one cycle following the triggering edge.
- Back-to-back codewords with no idle cycle are supported; the frame_sync of codeword k+1 may follow the Nth symbol of codeword k directly.

## Configuration
- ERASURE_CNT_EN defined: i_erasure is counted as specified.
- ERASURE_CNT_EN undefined:
  - i_erasure is ignored and the counter logic is removed.
  - o_erasures is constant 0.
  - All other behaviour is unchanged.

## Test plan
- N=32, NSYN=4, all 32 symbols 0x00, i_ready=1 → o_valid one cycle; o_syn=0, o_zero=1, o_short=0.
- Codeword with 0x01 at symbol index 30 (degree 1), rest 0x00 → S0=0x01, S1=0x02, S2=0x04, S3=0x08; o_zero=0.
- 0x01 as last symbol (degree 0) → all S_j=0x01; with N=28 parameterisation, same result after 28 symbols.
- Frame sync after 10 symbols, then a full 32-symbol codeword → o_short pulses once, exactly one o_valid result, matching the second codeword only.
- i_ready=0 across two back-to-back codewords → o_overrun pulses once at the second completion; o_syn shows the second result.
- ERASURE_CNT_EN defined, i_erasure on 3 symbols → o_erasures=3. Reset asserted mid-codeword → all outputs 0, and the next full codeword decodes correctly.
